// File: rtl/fp10_pkg.sv
// fp10_pkg: shared definitions for the 10-bit floating-point blocks.
// Format: [9] sign, [8:5] exponent (bias 7), [4:0] fraction, hidden leading 1.
// An exponent of 0 encodes zero. There are no Inf or NaN encodings.
package fp10_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 5;
  localparam int GUARD  = 2;
  localparam int BIAS   = 7;
  localparam int SIG_W  = 1 + FRAC_W + GUARD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALIGN   = 3'd1,
    COMPUTE = 3'd2,
    NORM    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [EXP_W+FRAC_W:0]   FP_ZERO   = 10'h000;
  localparam logic [EXP_W+FRAC_W-1:0] FP_MAXMAG = 9'h1FF;

endpackage

// File: rtl/fp_sub_seq_unpack.sv
// fp_unpack: combinational operand decode for the subtractor.
// The sign of b is inverted so that A - B becomes A + (-B). The operands are
// then ordered by magnitude on {exp,frac}; on a tie, a is taken as the larger.
// Ports:
//   a, b      : raw 10-bit operands (minuend, subtrahend)
//   sign_max  : sign of the larger-magnitude operand (also the result sign)
//   sign_min  : sign of the smaller-magnitude operand
//   exp_max   : exponent of the larger operand
//   sig_max   : significand {1,frac,guard} of the larger operand (0 if zero)
//   sig_min   : significand of the smaller operand, 0 if it would shift out
//   cnt       : number of alignment shifts still needed for sig_min
module fp_unpack
  import fp10_pkg::*;
(
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  sign_max,
  output logic                  sign_min,
  output logic [EXP_W-1:0]      exp_max,
  output logic [SIG_W-1:0]      sig_max,
  output logic [SIG_W-1:0]      sig_min,
  output logic [EXP_W-1:0]      cnt
);

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b, exp_min, diff;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic             a_is_max;

  assign sign_a = a[EXP_W+FRAC_W];
  assign sign_b = ~b[EXP_W+FRAC_W];
  assign exp_a  = a[EXP_W+FRAC_W-1:FRAC_W];
  assign exp_b  = b[EXP_W+FRAC_W-1:FRAC_W];

  // A zero exponent means the value is zero, so its hidden bit must not appear.
  assign sig_a = (exp_a == '0) ? '0 : {1'b1, a[FRAC_W-1:0], {GUARD{1'b0}}};
  assign sig_b = (exp_b == '0) ? '0 : {1'b1, b[FRAC_W-1:0], {GUARD{1'b0}}};

  // Comparing {exp,frac} as one unsigned field orders magnitudes directly.
  assign a_is_max = (a[EXP_W+FRAC_W-1:0] >= b[EXP_W+FRAC_W-1:0]);

  // A smaller operand shifted right by the full significand width would be
  // zero anyway, so it is zeroed here to keep the alignment loop short.
  always_comb begin
    sign_max = sign_b;
    sign_min = sign_a;
    exp_max  = exp_b;
    exp_min  = exp_a;
    sig_max  = sig_b;
    sig_min  = sig_a;
    if (a_is_max) begin
      sign_max = sign_a;
      sign_min = sign_b;
      exp_max  = exp_a;
      exp_min  = exp_b;
      sig_max  = sig_a;
      sig_min  = sig_b;
    end
    diff = exp_max - exp_min;
    cnt  = diff;
    if (diff >= EXP_W'(SIG_W)) begin
      sig_min = '0;
      cnt     = '0;
    end
  end

endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle 10-bit floating-point subtractor, s = a - b.
// Alignment and normalisation use a one-bit-per-cycle shifter sequenced by
// the IDLE/ALIGN/COMPUTE/NORM/DONE state machine. Rounding is truncation.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake; in_ready is high only in IDLE
//   a, b                 : minuend and subtrahend
//   out_valid / out_ready: result handshake; s/ovf/unf held while out_valid
//   s                    : result
//   ovf                  : result saturated to max magnitude
//   unf                  : result flushed to zero
module fp_sub_seq
  import fp10_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] s,
  output logic                  ovf,
  output logic                  unf
);

  state_t           state, state_nxt;
  logic             sign_max_r, sign_min_r;
  logic [EXP_W:0]   exp_r;
  logic [SIG_W-1:0] sig_max_r, sig_min_r;
  logic [EXP_W-1:0] cnt_r;
  logic [SIG_W:0]   sum_r;

  logic             u_sign_max, u_sign_min;
  logic [EXP_W-1:0] u_exp_max, u_cnt;
  logic [SIG_W-1:0] u_sig_max, u_sig_min;

  logic norm_zero, norm_ovf, norm_unf, norm_ok;

  fp_unpack u_unpack (
    .a        (a),
    .b        (b),
    .sign_max (u_sign_max),
    .sign_min (u_sign_min),
    .exp_max  (u_exp_max),
    .sig_max  (u_sig_max),
    .sig_min  (u_sig_min),
    .cnt      (u_cnt)
  );

  // Normalisation decisions, in priority order. exp_r carries one extra bit
  // so that an increment from 15 is visible as an overflow.
  assign norm_zero = (sum_r == '0);
  assign norm_ovf  = sum_r[SIG_W] && (exp_r == 5'd15);
  assign norm_unf  = !norm_zero && !sum_r[SIG_W] && !sum_r[SIG_W-1] && (exp_r == 5'd1);
  assign norm_ok   = !sum_r[SIG_W] && sum_r[SIG_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs. NORM loops until one terminating
  // condition holds; DONE waits for the consumer.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ALIGN;
      end
      ALIGN:   if (cnt_r == '0) state_nxt = COMPUTE;
      COMPUTE: state_nxt = NORM;
      NORM:    if (norm_zero || norm_ovf || norm_unf || norm_ok) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, align, add/subtract, then normalise one bit per cycle.
  // s/ovf/unf are only written when NORM finishes, so they stay stable in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_max_r <= 1'b0;
      sign_min_r <= 1'b0;
      exp_r      <= '0;
      sig_max_r  <= '0;
      sig_min_r  <= '0;
      cnt_r      <= '0;
      sum_r      <= '0;
      s          <= FP_ZERO;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_max_r <= u_sign_max;
            sign_min_r <= u_sign_min;
            exp_r      <= {1'b0, u_exp_max};
            sig_max_r  <= u_sig_max;
            sig_min_r  <= u_sig_min;
            cnt_r      <= u_cnt;
          end
        end
        ALIGN: begin
          if (cnt_r != '0) begin
            sig_min_r <= sig_min_r >> 1;
            cnt_r     <= cnt_r - 1'b1;
          end
        end
        COMPUTE: begin
          // Max >= Min in magnitude, so the difference is never negative.
          if (sign_max_r == sign_min_r) sum_r <= {1'b0, sig_max_r} + {1'b0, sig_min_r};
          else                          sum_r <= {1'b0, sig_max_r} - {1'b0, sig_min_r};
        end
        NORM: begin
          if (norm_zero) begin
            s   <= FP_ZERO;
            ovf <= 1'b0;
            unf <= 1'b0;
          end else if (sum_r[SIG_W]) begin
            sum_r <= sum_r >> 1;
            exp_r <= exp_r + 1'b1;
            if (norm_ovf) begin
              s   <= {sign_max_r, FP_MAXMAG};
              ovf <= 1'b1;
              unf <= 1'b0;
            end
          end else if (!sum_r[SIG_W-1]) begin
            sum_r <= sum_r << 1;
            exp_r <= exp_r - 1'b1;
            if (norm_unf) begin
              s   <= FP_ZERO;
              ovf <= 1'b0;
              unf <= 1'b1;
            end
          end else begin
            s   <= {sign_max_r, exp_r[EXP_W-1:0], sum_r[SIG_W-2:GUARD]};
            ovf <= 1'b0;
            unf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: directed-vector bench for fp_sub_seq. The driver pushes the
// hand-computed result and latency into a queue on acceptance; a monitor pops
// and compares on every output hand-off.
module tb_fp_sub_seq;

  typedef struct {
    logic [9:0] s;
    logic       ovf;
    logic       unf;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] a = '0;
  logic [9:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] s;
  logic       ovf;
  logic       unf;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   seen_valid = 1'b0;

  fp_sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Issue one operand pair; when push is set, the expected result is queued.
  task automatic apply_stimulus(input logic [9:0] av, input logic [9:0] bv,
                                input logic [9:0] es, input logic eo, input logic eu,
                                input int lat, input bit push);
    exp_t e;
    int   k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check_output("in_ready_timeout", in_ready, 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.s = es; e.ovf = eo; e.unf = eu; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) check_output("result_timeout", exp_q.size(), 0);
  endtask

  // Monitor: latency on first sight of out_valid, result on hand-off.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_out_valid", out_valid, 0);
      end else begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          check_output("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end
        if (out_ready) begin
          check_output("s", s, exp_q[0].s);
          check_output("ovf", ovf, exp_q[0].ovf);
          check_output("unf", unf, exp_q[0].unf);
          void'(exp_q.pop_front());
          seen_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    #12;
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_s", s, 0);
    check_output("reset_ovf", ovf, 0);
    check_output("reset_unf", unf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(10'h0E0, 10'h0E0, 10'h000, 1'b0, 1'b0, 3, 1'b1);
    wait_done();
    apply_stimulus(10'h110, 10'h0E0, 10'h100, 1'b0, 1'b0, 4, 1'b1);
    wait_done();
    apply_stimulus(10'h0E0, 10'h2E0, 10'h100, 1'b0, 1'b0, 4, 1'b1);
    wait_done();
    apply_stimulus(10'h0E1, 10'h0E0, 10'h040, 1'b0, 1'b0, 8, 1'b1);
    wait_done();
    apply_stimulus(10'h1FF, 10'h3FF, 10'h1FF, 1'b1, 1'b0, 3, 1'b1);
    wait_done();
    apply_stimulus(10'h021, 10'h020, 10'h000, 1'b0, 1'b1, 3, 1'b1);
    wait_done();
    apply_stimulus(10'h0E0, 10'h110, 10'h300, 1'b0, 1'b0, 4, 1'b1);
    wait_done();

    // Exponent difference of 8 with a stalled consumer.
    out_ready = 1'b0;
    apply_stimulus(10'h1E0, 10'h0E0, 10'h1E0, 1'b0, 1'b0, 3, 1'b1);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output("stall_out_valid", out_valid, 1);
      check_output("stall_s", s, 10'h1E0);
      check_output("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_done();
    @(posedge clk); #1;
    check_output("idle_after_handoff_out_valid", out_valid, 0);

    // Reset while aligning: the operation is abandoned with no output.
    apply_stimulus(10'h110, 10'h0E0, 10'h000, 1'b0, 1'b0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_out_valid", out_valid, 0);
    check_output("async_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    apply_stimulus(10'h0E0, 10'h0E0, 10'h000, 1'b0, 1'b0, 3, 1'b1);
    wait_done();

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
